// File: rtl/dump_sm_if.sv
// Signal bundle between the dump state machine, the sample-RAM read mux and the UART.
// master: the dump SM side; slave: the environment (command processor, RAM interface, UART).
interface dump_sm_if #(
    parameter int ADDR_W = 9
);
    logic              dump_start;
    logic [1:0]        dump_ch;
    logic              cap_busy;
    logic [ADDR_W-1:0] trace_end;
    logic [7:0]        read_data;
    logic              tx_done;
    logic              dump_en;
    logic [1:0]        ch_sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        tx_data;
    logic              trmt;
    logic              busy;
    logic              dump_done;
    logic              dump_err;

    modport master (
        input  dump_start, dump_ch, cap_busy, trace_end, read_data, tx_done,
        output dump_en, ch_sel, addr, tx_data, trmt, busy, dump_done, dump_err
    );

    modport slave (
        output dump_start, dump_ch, cap_busy, trace_end, read_data, tx_done,
        input  dump_en, ch_sel, addr, tx_data, trmt, busy, dump_done, dump_err
    );
endinterface

// File: rtl/dump_sm.sv
// Dumps one channel's circular capture buffer, oldest sample first, to the UART.
//   state | meaning
//   IDLE  | waiting for dump_start
//   RD    | dump_en high for one cycle at addr/ch_sel
//   LD    | read_data valid; load tx_data and strobe trmt
//   TX    | waiting for tx_done from the UART
module dump_sm #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 384
) (
    input  logic      clk,
    input  logic      rst_n,
    dump_sm_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, LD, TX} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [1:0]        ch_sel_q, ch_sel_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [ADDR_W-1:0] count_q, count_nxt;
    logic [7:0]        tx_data_q, tx_data_nxt;
    logic              trmt_q, trmt_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;

    // DEPTH need not be a power of two, so the address wraps explicitly.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_sel_q  <= 2'b00;
            addr_q    <= '0;
            count_q   <= '0;
            tx_data_q <= 8'h00;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch_sel_q  <= ch_sel_nxt;
            addr_q    <= addr_nxt;
            count_q   <= count_nxt;
            tx_data_q <= tx_data_nxt;
            trmt_q    <= trmt_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ch_sel_nxt  = ch_sel_q;
        addr_nxt    = addr_q;
        count_nxt   = count_q;
        tx_data_nxt = tx_data_q;
        busy_nxt    = busy_q;
        trmt_nxt    = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dump_start) begin
                    if ((bus.dump_ch != 2'b00) && !bus.cap_busy) begin
                        ch_sel_nxt = bus.dump_ch;
                        addr_nxt   = wrap_inc(bus.trace_end);
                        count_nxt  = '0;
                        busy_nxt   = 1'b1;
                        state_nxt  = RD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RD: state_nxt = LD;
            LD: begin
                tx_data_nxt = bus.read_data;
                trmt_nxt    = 1'b1;
                state_nxt   = TX;
            end
            TX: begin
                if (bus.tx_done) begin
                    if (count_q == LAST) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        count_nxt = count_q + ADDR_W'(1);
                        addr_nxt  = wrap_inc(addr_q);
                        state_nxt = RD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.dump_en   = (state == RD);
    assign bus.ch_sel    = ch_sel_q;
    assign bus.addr      = addr_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.trmt      = trmt_q;
    assign bus.busy      = busy_q;
    assign bus.dump_done = done_q;
    assign bus.dump_err  = err_q;
endmodule

// File: tb/tb_dump_sm.sv
// Self-checking bench for dump_sm: RAM and UART models plus a queue-based reference
// of the expected byte order, with directed and randomized dumps.
module tb_dump_sm;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dump_sm_if #(.ADDR_W(ADDR_W)) bus ();

    dump_sm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int uart_dly = 20;
    int start_cyc = 0;

    logic [7:0] mem [4][DEPTH];

    logic [7:0]        tx_q[$];
    int                trmt_cyc[$];
    logic [ADDR_W-1:0] en_addr[$];
    logic [1:0]        en_ch[$];
    int                en_cyc[$];
    int                done_cnt, done_cyc, err_cnt, err_cyc, last_txd_cyc;
    logic              done_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample RAM: read data valid the cycle after dump_en, garbage otherwise.
    always @(posedge clk) begin
        if (bus.dump_en) bus.read_data <= mem[bus.ch_sel][bus.addr];
        else             bus.read_data <= 8'($urandom);
    end

    // UART: tx_done uart_dly cycles after the trmt cycle (0 = same cycle).
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.trmt === 1'b1) begin
                if (uart_dly > 0) begin
                    repeat (uart_dly) @(posedge clk);
                    #1;
                end
                bus.tx_done = 1'b1;
                @(posedge clk);
                #1;
                bus.tx_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.dump_en === 1'b1) begin
            en_addr.push_back(bus.addr);
            en_ch.push_back(bus.ch_sel);
            en_cyc.push_back(cyc);
        end
        if (bus.trmt === 1'b1) begin
            tx_q.push_back(bus.tx_data);
            trmt_cyc.push_back(cyc);
        end
        if (bus.tx_done === 1'b1 && bus.busy === 1'b1) last_txd_cyc = cyc;
        if (bus.dump_done === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = bus.busy;
        end
        if (bus.dump_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        tx_q.delete();
        trmt_cyc.delete();
        en_addr.delete();
        en_ch.delete();
        en_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        err_cnt = 0;
        err_cyc = -1;
        last_txd_cyc = -1;
        done_busy = 1'bx;
    endtask

    task automatic fill_mem();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < DEPTH; a++)
                mem[c][a] = (c == 2) ? 8'(8'hA0 + a) : 8'($urandom);
    endtask

    // Called at negedge+1; the start is sampled on the next rising edge.
    task automatic pulse_start(input logic [1:0] ch, input int te);
        bus.dump_ch    = ch;
        bus.trace_end  = ADDR_W'(te);
        bus.dump_start = 1'b1;
        start_cyc      = cyc;
        @(negedge clk);
        #1;
        bus.dump_start = 1'b0;
    endtask

    task automatic wait_done(input bit repulse);
        bit rp_done = 0;
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            #1;
            bus.dump_start = 1'b0;
            if (repulse && !rp_done && tx_q.size() == 3) begin
                bus.dump_ch    = 2'b11;
                bus.trace_end  = '0;
                bus.dump_start = 1'b1;
                rp_done = 1;
            end
            n++;
        end
        bus.dump_start = 1'b0;
        chk("done_within_bound", 32'(done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic check_dump(input string tag, input logic [1:0] ch, input int te,
                              input bit zero_dly);
        chk({tag, "_nbytes"}, tx_q.size(), DEPTH);
        chk({tag, "_nreads"}, en_addr.size(), DEPTH);
        chk({tag, "_ntrmt"}, trmt_cyc.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            int a = (te + 1 + i) % DEPTH;
            if (i < tx_q.size())
                chk($sformatf("%s_byte%0d", tag, i), tx_q[i], mem[ch][a]);
            if (i < en_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), en_addr[i], a);
                chk($sformatf("%s_chsel%0d", tag, i), en_ch[i], ch);
            end
            if (i < en_cyc.size() && i < trmt_cyc.size())
                chk($sformatf("%s_trmt_lat%0d", tag, i), trmt_cyc[i] - en_cyc[i], 2);
            if (zero_dly && i > 0 && i < en_cyc.size())
                chk($sformatf("%s_byte_period%0d", tag, i), en_cyc[i] - en_cyc[i-1], 3);
        end
        if (en_cyc.size() > 0) begin
            chk({tag, "_first_en_lat"}, en_cyc[0] - start_cyc, 1);
            if (zero_dly) chk({tag, "_total_cycles"}, done_cyc - en_cyc[0], 24);
        end
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_after_txdone"}, done_cyc - last_txd_cyc, 1);
        chk({tag, "_busy_with_done"}, done_busy, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
        chk({tag, "_no_err"}, err_cnt, 0);
        chk({tag, "_chsel_held"}, bus.ch_sel, ch);
    endtask

    task automatic run_dump(input string tag, input logic [1:0] ch, input int te,
                            input int dly, input bit repulse);
        clear_mon();
        uart_dly = dly;
        pulse_start(ch, te);
        chk({tag, "_busy_started"}, bus.busy, 1);
        wait_done(repulse);
        check_dump(tag, ch, te, dly == 0);
    endtask

    task automatic run_err(input string tag, input logic [1:0] ch, input logic cb);
        clear_mon();
        bus.cap_busy = cb;
        pulse_start(ch, 0);
        repeat (5) @(negedge clk);
        #1;
        chk({tag, "_err_pulses"}, err_cnt, 1);
        chk({tag, "_err_timing"}, err_cyc - start_cyc, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_no_read"}, en_addr.size(), 0);
        chk({tag, "_no_trmt"}, tx_q.size(), 0);
        bus.cap_busy = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_dump_en"}, bus.dump_en, 0);
        chk({tag, "_trmt"}, bus.trmt, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_dump_done"}, bus.dump_done, 0);
        chk({tag, "_dump_err"}, bus.dump_err, 0);
        chk({tag, "_ch_sel"}, bus.ch_sel, 0);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
    endtask

    initial begin
        bus.dump_start = 1'b0;
        bus.dump_ch    = 2'b00;
        bus.cap_busy   = 1'b0;
        bus.trace_end  = '0;
        fill_mem();
        clear_mon();
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        run_dump("ch2_te5", 2'b10, 5, 20, 1'b0);
        run_dump("ch2_te7", 2'b10, 7, 20, 1'b0);
        run_err("err_ch00", 2'b00, 1'b0);
        run_err("err_capbusy", 2'b01, 1'b1);
        run_dump("repulse", 2'b10, 5, 6, 1'b1);

        // Asynchronous reset while the block waits in TX.
        clear_mon();
        uart_dly = 20;
        pulse_start(2'b10, 5);
        for (int n = 0; n < 200 && tx_q.size() < 2; n++) begin
            @(negedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        #1;
        chk("pre_reset_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        repeat (25) @(negedge clk);
        #1;
        chk("async_rst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        run_dump("post_rst_te2", 2'b10, 2, 3, 1'b0);

        run_dump("zero_dly", 2'b10, 5, 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            logic [1:0] ch;
            fill_mem();
            ch = 2'($urandom_range(1, 3));
            run_dump($sformatf("rand%0d", k), ch, int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, 4)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
